// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB/CBC/CTR block-mode sequencer in front of an external single-block AES core.
// Optional feature macro AES_MODE_CTR_EN enables CTR mode and its low-word counter incrementer.
module aes_mode_ctrl #(
    parameter int NBLK_W = 16,
    parameter int CTR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_decrypt,
    input  logic [127:0]      cfg_key,
    input  logic [127:0]      cfg_iv,
    input  logic [NBLK_W-1:0] cfg_nblocks,
    output logic              cfg_err,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic              core_start,
    output logic [127:0]      core_din,
    output logic [127:0]      core_key,
    output logic              core_decrypt,
    input  logic [127:0]      core_dout,
    input  logic              core_done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_RUN, S_OUT} state_t;

    localparam logic [1:0]        MODE_ECB = 2'd0;
    localparam logic [1:0]        MODE_CBC = 2'd1;
    localparam logic [1:0]        MODE_CTR = 2'd2;
    localparam logic [NBLK_W-1:0] ONE_BLK  = NBLK_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              decrypt_q, decrypt_d;
    logic [127:0]      key_q, key_d;
    logic [127:0]      chain_q, chain_d;
    logic [127:0]      blk_q, blk_d;
    logic [127:0]      out_data_q, out_data_d;
    logic [127:0]      core_din_q, core_din_d;
    logic [NBLK_W-1:0] remaining_q, remaining_d;
    logic              core_start_q, core_start_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              mode_ok;
    logic [127:0]      chain_inc;

`ifdef AES_MODE_CTR_EN
    // Only the low CTR_W bits count; a shift of 128 yields 0 so the mask becomes all ones.
    localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;
    assign chain_inc = (chain_q & ~CTR_MASK) | ((chain_q + 128'd1) & CTR_MASK);
    assign mode_ok   = (cfg_mode != 2'd3);
`else
    assign chain_inc = chain_q;
    assign mode_ok   = (cfg_mode == MODE_ECB) || (cfg_mode == MODE_CBC);
`endif

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        decrypt_d    = decrypt_q;
        key_d        = key_q;
        chain_d      = chain_q;
        blk_d        = blk_q;
        out_data_d   = out_data_q;
        core_din_d   = core_din_q;
        remaining_d  = remaining_q;
        core_start_d = 1'b0;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if (mode_ok && (cfg_nblocks != '0)) begin
                        mode_d      = cfg_mode;
                        decrypt_d   = cfg_decrypt;
                        key_d       = cfg_key;
                        chain_d     = cfg_iv;
                        remaining_d = cfg_nblocks;
                        state_d     = S_WAIT_IN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    blk_d        = in_data;
                    core_start_d = 1'b1;
                    state_d      = S_RUN;
                    case (mode_q)
                        MODE_CBC: core_din_d = decrypt_q ? in_data : (in_data ^ chain_q);
                        MODE_CTR: core_din_d = chain_q;
                        default:  core_din_d = in_data;
                    endcase
                end
            end
            S_RUN: begin
                // A done seen in the launch cycle can only be stale, so it is not taken as the result.
                if (core_done && !core_start_q) begin
                    state_d = S_OUT;
                    case (mode_q)
                        MODE_CBC: begin
                            if (decrypt_q) begin
                                out_data_d = core_dout ^ chain_q;
                                chain_d    = blk_q;
                            end else begin
                                out_data_d = core_dout;
                                chain_d    = core_dout;
                            end
                        end
                        MODE_CTR: begin
                            out_data_d = core_dout ^ blk_q;
                            chain_d    = chain_inc;
                        end
                        default: out_data_d = core_dout;
                    endcase
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    remaining_d = remaining_q - ONE_BLK;
                    if (remaining_q == ONE_BLK) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_ECB;
            decrypt_q    <= 1'b0;
            key_q        <= '0;
            chain_q      <= '0;
            blk_q        <= '0;
            out_data_q   <= '0;
            core_din_q   <= '0;
            remaining_q  <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            decrypt_q    <= decrypt_d;
            key_q        <= key_d;
            chain_q      <= chain_d;
            blk_q        <= blk_d;
            out_data_q   <= out_data_d;
            core_din_q   <= core_din_d;
            remaining_q  <= remaining_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign in_ready     = (state_q == S_WAIT_IN);
    assign out_valid    = (state_q == S_OUT);
    assign out_data     = out_data_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign core_start   = core_start_q;
    assign core_din     = core_din_q;
    assign core_key     = key_q;
    assign core_decrypt = decrypt_q && (mode_q != MODE_CTR);

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb_aes_mode_ctrl: randomized self-checking bench for aes_mode_ctrl with a mock AES core
// (NIST known answers plus an invertible stand-in cipher) and a message-level reference model.
module tb_aes_mode_ctrl;

    localparam int NBLK_W = 16;
    localparam int CTR_W  = 32;
`ifdef AES_MODE_CTR_EN
    localparam bit CTR_EN = 1'b1;
`else
    localparam bit CTR_EN = 1'b0;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CTR_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [1:0]        cfg_mode;
    logic              cfg_decrypt;
    logic [127:0]      cfg_key;
    logic [127:0]      cfg_iv;
    logic [NBLK_W-1:0] cfg_nblocks;
    logic              cfg_err, busy, done;
    logic              in_valid, in_ready;
    logic [127:0]      in_data;
    logic              out_valid, out_ready;
    logic [127:0]      out_data;
    logic              core_start;
    logic [127:0]      core_din, core_key;
    logic              core_decrypt;
    logic [127:0]      core_dout = '0;
    logic              core_done = 1'b0;

    always #5 clk = ~clk;

    aes_mode_ctrl #(.NBLK_W(NBLK_W), .CTR_W(CTR_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_decrypt(cfg_decrypt),
        .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_nblocks(cfg_nblocks),
        .cfg_err(cfg_err), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_start(core_start), .core_din(core_din), .core_key(core_key),
        .core_decrypt(core_decrypt), .core_dout(core_dout), .core_done(core_done)
    );

    int vectors = 0;
    int miscompares = 0;

    // Mock core: real AES answers for the known vectors, an invertible toy cipher otherwise.
    function automatic logic [127:0] toy_enc(input logic [127:0] k, input logic [127:0] x);
        logic [127:0] z;
        if (k == K1 && x == 128'h00112233445566778899aabbccddeeff) return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        if (k == K2 && x == 128'h6bc0bce12a459991e134741a7f9e1925) return 128'h7649abac8119b246cee98e9b12e9197d;
        if (k == K2 && x == CTR_IV)                                 return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
        if (k == K2 && x == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00) return 128'h362b7c3c6773516318a077d7fc5073ae;
        z = x ^ k;
        return {z[120:0], z[127:121]} ^ {k[63:0], k[127:64]};
    endfunction

    function automatic logic [127:0] toy_dec(input logic [127:0] k, input logic [127:0] y);
        logic [127:0] z;
        if (k == K1 && y == 128'h69c4e0d86a7b0430d8cdb78070b4c55a) return 128'h00112233445566778899aabbccddeeff;
        if (k == K2 && y == 128'h7649abac8119b246cee98e9b12e9197d) return 128'h6bc0bce12a459991e134741a7f9e1925;
        z = y ^ {k[63:0], k[127:64]};
        return {z[6:0], z[127:7]} ^ k;
    endfunction

    int           core_lat = 2;
    int           core_cnt = 0;
    bit           core_busy = 1'b0;
    logic [127:0] cm_din, cm_key;
    logic         cm_dec;
    int           core_starts = 0;
    logic [127:0] din_log[$];

    always @(posedge clk) begin
        #1;
        core_done = 1'b0;
        if (core_busy) begin
            if (core_cnt == 0) begin
                core_done = 1'b1;
                core_dout = cm_dec ? toy_dec(cm_key, cm_din) : toy_enc(cm_key, cm_din);
                core_busy = 1'b0;
            end else begin
                core_cnt--;
            end
        end
        if (core_start) begin
            core_busy = 1'b1;
            core_cnt  = core_lat - 1;
            cm_din    = core_din;
            cm_key    = core_key;
            cm_dec    = core_decrypt;
            core_starts++;
            din_log.push_back(core_din);
        end
    end

    // Message-level reference: block i output from the mode's chaining rule.
    logic [127:0] exp_out[16];
    function automatic void ref_model(input logic [1:0] m, input logic d, input logic [127:0] k,
                                      input logic [127:0] iv, input logic [127:0] blocks[16], input int n);
        logic [127:0] prev;
        prev = iv;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'd0: exp_out[i] = d ? toy_dec(k, blocks[i]) : toy_enc(k, blocks[i]);
                2'd1: begin
                    if (d) begin
                        exp_out[i] = toy_dec(k, blocks[i]) ^ prev;
                        prev = blocks[i];
                    end else begin
                        exp_out[i] = toy_enc(k, blocks[i] ^ prev);
                        prev = exp_out[i];
                    end
                end
                default: begin
                    exp_out[i] = toy_enc(k, prev) ^ blocks[i];
                    prev[CTR_W-1:0] = prev[CTR_W-1:0] + 1'b1;
                end
            endcase
        end
    endfunction

    logic [127:0] blk_in[16];
    logic [127:0] blk_got[16];
    logic         got_done, got_busy;
    bit           timed_out;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_cfg(input logic [1:0] m, input logic d, input logic [127:0] k,
                             input logic [127:0] iv, input int n);
        cfg_mode    = m;
        cfg_decrypt = d;
        cfg_key     = k;
        cfg_iv      = iv;
        cfg_nblocks = NBLK_W'(n);
        cfg_start   = 1'b1;
        tick();
        cfg_start   = 1'b0;
    endtask

    // Feeds blk_in[0..n-1], collects outputs with random backpressure (0 = none).
    task automatic stream(input int n, input int bp);
        int w;
        timed_out = 1'b0;
        got_done  = 1'b0;
        got_busy  = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!in_ready && w < 200) begin tick(); w++; end
            if (!in_ready) begin timed_out = 1'b1; return; end
            in_valid = 1'b1;
            in_data  = blk_in[i];
            tick();
            in_valid = 1'b0;
            w = 0;
            forever begin
                out_ready = out_valid && ($urandom_range(0, bp) == 0);
                if (out_ready) begin
                    blk_got[i] = out_data;
                    tick();
                    out_ready = 1'b0;
                    break;
                end
                if (w >= 200) begin timed_out = 1'b1; return; end
                tick();
                w++;
            end
            got_done = done;
            got_busy = busy;
        end
    endtask

    task automatic applyStimulus_dummy_guard();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({busy, done, cfg_err, in_ready, out_valid, core_start} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got=%b exp=000000", {busy, done, cfg_err, in_ready, out_valid, core_start});
        end
        vectors++;
        if (out_data !== 128'h0 || core_din !== 128'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data got out=%h din=%h exp 0", out_data, core_din);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ecb();
        start_cfg(2'd0, 1'b0, K1, 128'h0, 1);
        vectors++;
        if ({busy, in_ready} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL ecb_start busy,in_ready got=%b exp=11", {busy, in_ready});
        end
        blk_in[0] = 128'h00112233445566778899aabbccddeeff;
        stream(1, 0);
        vectors++;
        if (timed_out !== 1'b0 || blk_got[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            miscompares++;
            $display("[TB] FAIL ecb_out got=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a timeout=%0d", blk_got[0], timed_out);
        end
        vectors++;
        if ({got_done, got_busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL ecb_done done,busy got=%b exp=10", {got_done, got_busy});
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ecb_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_cbc();
        start_cfg(2'd1, 1'b0, K2, K1, 1);
        blk_in[0] = P1;
        stream(1, 1);
        vectors++;
        if (timed_out !== 1'b0 || blk_got[0] !== 128'h7649abac8119b246cee98e9b12e9197d) begin
            miscompares++;
            $display("[TB] FAIL cbc_enc got=%h exp=7649abac8119b246cee98e9b12e9197d", blk_got[0]);
        end
        tick();
        start_cfg(2'd1, 1'b1, K2, K1, 1);
        blk_in[0] = 128'h7649abac8119b246cee98e9b12e9197d;
        stream(1, 1);
        vectors++;
        if (timed_out !== 1'b0 || blk_got[0] !== P1 || got_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cbc_dec got=%h done=%b exp=%h done=1", blk_got[0], got_done, P1);
        end
        tick();
    endtask

    task automatic test_ctr();
        logic [127:0] iv;
        if (CTR_EN) begin
            din_log.delete();
            start_cfg(2'd2, 1'b1, K2, CTR_IV, 2);
            blk_in[0] = P1;
            blk_in[1] = P2;
            stream(2, 1);
            vectors++;
            if (timed_out !== 1'b0 || blk_got[0] !== 128'h874d6191b620e3261bef6864990db6ce) begin
                miscompares++;
                $display("[TB] FAIL ctr_blk0 got=%h exp=874d6191b620e3261bef6864990db6ce", blk_got[0]);
            end
            vectors++;
            if (blk_got[1] !== 128'h9806f66b7970fdff8617187bb9fffdff || got_done !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL ctr_blk1 got=%h done=%b exp=9806f66b7970fdff8617187bb9fffdff", blk_got[1], got_done);
            end
            vectors++;
            if (din_log.size() != 2 || din_log[din_log.size()-1] !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00) begin
                miscompares++;
                $display("[TB] FAIL ctr_din1 got=%h n=%0d exp=f0f1f2f3f4f5f6f7f8f9fafbfcfdff00", din_log[din_log.size()-1], din_log.size());
            end
            tick();
            din_log.delete();
            iv = 128'h0123456789abcdef01234567ffffffff;
            blk_in[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
            blk_in[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
            ref_model(2'd2, 1'b0, K1, iv, blk_in, 2);
            start_cfg(2'd2, 1'b0, K1, iv, 2);
            stream(2, 0);
            vectors++;
            if (din_log.size() != 2 || din_log[din_log.size()-1] !== {iv[127:32], 32'h0}) begin
                miscompares++;
                $display("[TB] FAIL ctr_wrap_din got=%h exp=%h", din_log[din_log.size()-1], {iv[127:32], 32'h0});
            end
            vectors++;
            if (timed_out !== 1'b0 || blk_got[1] !== exp_out[1]) begin
                miscompares++;
                $display("[TB] FAIL ctr_wrap_out got=%h exp=%h", blk_got[1], exp_out[1]);
            end
        end else begin
            start_cfg(2'd2, 1'b0, K2, CTR_IV, 2);
            vectors++;
            if ({cfg_err, busy} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL ctr_disabled cfg_err,busy got=%b exp=10", {cfg_err, busy});
            end
        end
        tick();
    endtask

    task automatic test_errors();
        start_cfg(2'd3, 1'b0, K1, 128'h0, 1);
        vectors++;
        if ({cfg_err, busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL err_mode3 cfg_err,busy got=%b exp=10", {cfg_err, busy});
        end
        tick();
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_pulse got=%b exp=0", cfg_err);
        end
        start_cfg(2'd0, 1'b0, K1, 128'h0, 0);
        vectors++;
        if ({cfg_err, busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL err_nblocks0 cfg_err,busy got=%b exp=10", {cfg_err, busy});
        end
        tick();
        start_cfg(2'd0, 1'b0, K1, 128'h0, 1);
        start_cfg(2'd3, 1'b0, K2, 128'h0, 5);
        vectors++;
        if ({cfg_err, busy, in_ready} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL err_busy_ignored cfg_err,busy,in_ready got=%b exp=011", {cfg_err, busy, in_ready});
        end
        start_cfg(2'd1, 1'b1, K2, 128'h0, 5);
        blk_in[0] = 128'h00112233445566778899aabbccddeeff;
        stream(1, 0);
        vectors++;
        if (timed_out !== 1'b0 || blk_got[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || got_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_busy_cfg_kept got=%h done=%b exp=69c4e0d86a7b0430d8cdb78070b4c55a", blk_got[0], got_done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [127:0] hold;
        int           starts0;
        int           w;
        core_lat = 3;
        start_cfg(2'd0, 1'b0, K1, 128'h0, 1);
        in_valid = 1'b1;
        in_data  = 128'h00112233445566778899aabbccddeeff;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({core_start, in_ready} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL bp_launch core_start,in_ready got=%b exp=10", {core_start, in_ready});
        end
        w = 0;
        while (!core_done && w < 50) begin tick(); w++; end
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_out_valid_latency got=%b exp=1", out_valid);
        end
        hold    = out_data;
        starts0 = core_starts;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if ({out_valid, in_ready} !== 2'b10 || out_data !== hold) begin
                miscompares++;
                $display("[TB] FAIL bp_hold cycle=%0d valid,in_ready=%b data=%h exp 10 data=%h", c, {out_valid, in_ready}, out_data, hold);
            end
        end
        vectors++;
        if (core_starts != starts0 || hold !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            miscompares++;
            $display("[TB] FAIL bp_data starts=%0d/%0d data=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a", core_starts, starts0, hold);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if ({done, busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL bp_done done,busy got=%b exp=10", {done, busy});
        end
        tick();
    endtask

    task automatic test_random();
        logic [1:0]   m;
        logic         d;
        logic [127:0] k, iv;
        int           n;
        for (int t = 0; t < 25; t++) begin
            m  = CTR_EN ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 1));
            d  = 1'($urandom_range(0, 1));
            k  = {$urandom(), $urandom(), $urandom(), $urandom()};
            iv = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) iv[31:0] = 32'hffffffff;
            n  = $urandom_range(1, 4);
            core_lat = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) blk_in[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            ref_model(m, d, k, iv, blk_in, n);
            start_cfg(m, d, k, iv, n);
            stream(n, 2);
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (timed_out !== 1'b0 || blk_got[i] !== exp_out[i]) begin
                    miscompares++;
                    $display("[TB] FAIL rand_blk msg=%0d mode=%0d dec=%0d blk=%0d got=%h exp=%h timeout=%0d", t, m, d, i, blk_got[i], exp_out[i], timed_out);
                end
            end
            vectors++;
            if ({got_done, got_busy} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL rand_done msg=%0d done,busy got=%b exp=10", t, {got_done, got_busy});
            end
            tick();
        end
    endtask

    task automatic test_reset_run();
        int w;
        bit leak;
        core_lat = 6;
        start_cfg(2'd0, 1'b0, K1, 128'h0, 2);
        in_valid = 1'b1;
        in_data  = 128'h00112233445566778899aabbccddeeff;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({busy, done, cfg_err, in_ready, out_valid, core_start} !== 6'b0 || out_data !== 128'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_run flags=%b data=%h exp 0", {busy, done, cfg_err, in_ready, out_valid, core_start}, out_data);
        end
        leak = 1'b0;
        w = 0;
        while ((core_busy || core_done) && w < 20) begin
            tick();
            w++;
            if (busy || out_valid || done) leak = 1'b1;
        end
        tick();
        if (busy || out_valid || done) leak = 1'b1;
        vectors++;
        if (leak !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_stale_done got busy/out_valid/done activity exp none");
        end
        core_lat = 2;
        start_cfg(2'd0, 1'b0, K1, 128'h0, 1);
        blk_in[0] = 128'h00112233445566778899aabbccddeeff;
        stream(1, 1);
        vectors++;
        if (timed_out !== 1'b0 || blk_got[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || got_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_rerun got=%h done=%b exp=69c4e0d86a7b0430d8cdb78070b4c55a", blk_got[0], got_done);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst         = 1'b1;
        cfg_start   = 1'b0;
        cfg_mode    = 2'd0;
        cfg_decrypt = 1'b0;
        cfg_key     = '0;
        cfg_iv      = '0;
        cfg_nblocks = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        test_reset();
        test_ecb();
        test_cbc();
        test_ctr();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
